comm_slave: RTL

Receive-side counterpart of the command link. It assembles three UART bytes (command, data high, data low) into a 24-bit command, presents it to the downstream command processor with a sticky ready flag, and transmits a single-byte response back to the master. It sits between the board-level RX/TX pins and the command processor, wrapping the codebase `UART` transceiver.

---
 rtl/comm_pkg.sv | 8 +
 rtl/UART.sv | 104 ++++++++++
 rtl/comm_slave.sv | 129 ++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the command link slave
package comm_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_M, WAIT_L} rx_state_t;

   localparam int FRAME_BYTES     = 3;
   localparam int DEFAULT_TIMEOUT = 1_000_000;
   localparam int BAUD_DIV        = 16;
endpackage

// File: rtl/UART.sv
// rtl/UART.sv - 8N1 UART transceiver, BAUD_DIV clocks per bit
// rx_rdy is a level held until clr_rx_rdy; tx_done pulses once after the stop bit.
module UART
   import comm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       rx_rdy,
   input  logic       clr_rx_rdy,
   output logic [7:0] rx_data
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

   logic [9:0]    tx_sh_q;
   logic [3:0]    tx_bits_q;
   logic [CW-1:0] tx_cnt_q;
   logic          tx_busy_q, tx_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sh_q   <= '1;
         tx_bits_q <= '0;
         tx_cnt_q  <= '0;
         tx_busy_q <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         if (trmt && !tx_busy_q) begin
            tx_sh_q   <= {1'b1, tx_data, 1'b0};
            tx_busy_q <= 1'b1;
            tx_bits_q <= '0;
            tx_cnt_q  <= '0;
         end else if (tx_busy_q) begin
            if (tx_cnt_q == FULL) begin
               tx_cnt_q <= '0;
               tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
               if (tx_bits_q == 4'd9) begin
                  tx_busy_q <= 1'b0;
                  tx_done_q <= 1'b1;
               end else begin
                  tx_bits_q <= tx_bits_q + 4'd1;
               end
            end else begin
               tx_cnt_q <= tx_cnt_q + 1'b1;
            end
         end
      end
   end

   assign TX      = tx_sh_q[0];
   assign tx_done = tx_done_q;

   logic          rx_s1_q, rx_s2_q, rx_busy_q, rx_rdy_q;
   logic [3:0]    rx_bits_q;
   logic [CW-1:0] rx_cnt_q;
   logic [7:0]    rx_sh_q, rx_data_q;

   // First sample lands mid start bit; the start bit shifts out after the 9th sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_busy_q <= 1'b0;
         rx_bits_q <= '0;
         rx_cnt_q  <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         rx_rdy_q  <= 1'b0;
      end else begin
         rx_s1_q <= RX;
         rx_s2_q <= rx_s1_q;
         if (clr_rx_rdy) rx_rdy_q <= 1'b0;
         if (!rx_busy_q) begin
            if (!rx_s2_q) begin
               rx_busy_q <= 1'b1;
               rx_bits_q <= '0;
               rx_cnt_q  <= '0;
            end
         end else if (rx_cnt_q == ((rx_bits_q == 4'd0) ? HALF : FULL)) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bits_q == 4'd9) begin
               rx_busy_q <= 1'b0;
               rx_data_q <= rx_sh_q;
               rx_rdy_q  <= 1'b1;
            end else begin
               rx_bits_q <= rx_bits_q + 4'd1;
            end
         end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
         end
      end
   end

   assign rx_rdy  = rx_rdy_q;
   assign rx_data = rx_data_q;
endmodule

// File: rtl/comm_slave.sv
// rtl/comm_slave.sv - 3-byte command framer and 1-byte responder over UART
// Optional inter-byte timeout enabled by COMM_TIMEOUT_EN.
module comm_slave
   import comm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        frame_err
);
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic       rx_rdy, clr_rx_rdy, trmt, tx_done, timeout;
   logic [7:0] rx_data;
   rx_state_t  state_q;
   logic [7:0] cmd_q;
   logic [15:0] data_q;
   logic       cmd_rdy_q, busy_q, resp_sent_q;

   UART uart_i (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .trmt       (trmt),
      .tx_data    (resp),
      .tx_done    (tx_done),
      .rx_rdy     (rx_rdy),
      .clr_rx_rdy (clr_rx_rdy),
      .rx_data    (rx_data)
   );

   assign clr_rx_rdy = rx_rdy && (state_q == IDLE || state_q == WAIT_M || state_q == WAIT_L);

`ifdef COMM_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES - 1);

   logic [GAP_W-1:0] gap_q, gap_d;
   logic             frame_err_q;

   always_comb begin
      gap_d = '0;
      if ((state_q == WAIT_M || state_q == WAIT_L) && !rx_rdy) gap_d = gap_q + 1'b1;
   end

   assign timeout = (state_q == WAIT_M || state_q == WAIT_L) && (gap_q == GAP_MAX);

   // A byte arriving on the timeout cycle is accepted, so it suppresses the error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         gap_q       <= gap_d;
         frame_err_q <= timeout && !rx_rdy;
      end
   end

   assign frame_err = frame_err_q;
`else
   assign timeout   = 1'b0;
   assign frame_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         data_q    <= '0;
         cmd_rdy_q <= 1'b0;
      end else begin
         if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
         case (state_q)
            IDLE: if (rx_rdy) begin
               cmd_q     <= rx_data;
               cmd_rdy_q <= 1'b0;
               state_q   <= WAIT_M;
            end
            WAIT_M: if (rx_rdy) begin
               data_q[15:8] <= rx_data;
               state_q      <= WAIT_L;
            end else if (timeout) begin
               state_q <= IDLE;
            end
            WAIT_L: if (rx_rdy) begin
               data_q[7:0] <= rx_data;
               cmd_rdy_q   <= 1'b1;
               state_q     <= IDLE;
            end else if (timeout) begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign trmt = send_resp && !busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= 1'b0;
         resp_sent_q <= 1'b0;
      end else if (trmt) begin
         busy_q      <= 1'b1;
         resp_sent_q <= 1'b0;
      end else if (tx_done) begin
         busy_q      <= 1'b0;
         resp_sent_q <= 1'b1;
      end
   end

   assign cmd       = cmd_q;
   assign data      = data_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign resp_sent = resp_sent_q;
endmodule
